unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipeline's IF stage (instruction
//  fetch) and MEM stage (load/store). Sequences each access with a req/ack handshake,
//  holds the losing port in wait, and flags accesses whose ack never arrives.
//  Sits between the MIPS pipeline's fetch/memory stages and the shared memory model;
//  the hazard unit stalls the pipeline while a port's req is high and its ready is low.
// PARAMETERS
//  AW            32  address width (byte address, passed through unmodified)
//  DW            32  data width
//  TIMEOUT       16  cycles in an access state without mem_ack before abort (>=2)
//  STARVE_LIMIT   4  consecutive data grants allowed while IF waits (used only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  if_req     in   1   fetch request; held with if_addr stable until if_ready
//  if_addr    in   AW  fetch address
//  if_rdata   out  DW  fetched word, valid while if_ready=1
//  if_ready   out  1   one-cycle completion pulse for fetch
//  dm_req     in   1   data request; held with dm_we/addr/wdata stable until dm_ready
//  dm_we      in   1   1=store, 0=load
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  store data
//  dm_rdata   out  DW  load data, valid while dm_ready=1 (0 for stores)
//  dm_ready   out  1   one-cycle completion pulse for data
//  bus_err    out  1   one-cycle pulse, coincident with the ready that ends a timed-out access
//  mem_en     out  1   memory access strobe, held until mem_ack
//  mem_we     out  1   memory write enable (0 during IF access)
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, sampled on mem_ack
//  mem_ack    in   1   memory completion; may be asserted in the first mem_en cycle
// BEHAVIOUR
//  - FSM states: IDLE, I_ACC, D_ACC, DONE. All outputs registered except mem_* (decoded from state).
//  - Reset (async, immediate): state=IDLE; if_ready=dm_ready=bus_err=0; if_rdata=dm_rdata=0;
//    mem_en=mem_we=0; mem_addr=mem_wdata=0; timeout counter=0; starve counter=0.
//  - IDLE: dm_req=1 -> D_ACC (data priority); else if_req=1 -> I_ACC; else stay.
//  - I_ACC: mem_en=1, mem_we=0, mem_addr=if_addr. D_ACC: mem_en=1, mem_we=dm_we,
//    mem_addr=dm_addr, mem_wdata=dm_wdata. The timeout counter clears on entry and
//    increments each cycle.
//  - mem_ack seen in x_ACC -> DONE: owner's ready<=1; loads/fetches: rdata<=mem_rdata; stores: dm_rdata<=0.
//  - No ack when counter==TIMEOUT-1 -> DONE: owner's ready<=1, rdata<=0, bus_err<=1.
//  - DONE: mem_en=0; ready/bus_err high this cycle only; -> IDLE unconditionally.
//    This prevents a still-high req from being re-granted in the cycle it sees ready.
//  - Latency with zero-wait memory: req high in IDLE cycle N -> mem_en in N+1 -> ready in N+2.
//    Back-to-back accesses: one access per 3 cycles.
//  - Simultaneous if_req & dm_req in IDLE: data wins; IF stays pending. It is granted at
//    the first IDLE with dm_req=0 (or per the starve guard).
//  - A request dropped mid-access is a protocol violation; the access still completes
//    and ready still pulses.
//  - mem_ack outside x_ACC is ignored. Reset during x_ACC drops mem_en at once; no ready is produced.
//  - rdata outputs hold their last value after ready falls.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//    - A starve counter increments on each D grant made while if_req=1, and clears on any I grant.
//    - When it equals STARVE_LIMIT, IDLE grants IF even if dm_req=1.
//  ARB_STARVE_GUARD_EN undefined: strict data priority; the counter logic is not built.
// TESTING
//  1. Zero-wait memory (mem_ack=mem_en), if_req=1 if_addr=0x0000_0004, mem_rdata=0x2008_0005
//     -> mem_en at cycle 1, if_ready pulse at cycle 2 with if_rdata=0x2008_0005.
//  2. if_req and dm_req (load 0x0000_0040) both raised in the same cycle
//     -> D_ACC first and dm_ready first; if_ready 3 cycles later.
//  3. Store dm_we=1 dm_addr=0x0000_0010 dm_wdata=0xDEAD_BEEF, mem_ack delayed 3 cycles
//     -> mem_en/mem_we held 4 cycles with stable addr/data; dm_ready pulse with dm_rdata=0.
//  4. mem_ack tied 0, TIMEOUT=16, dm_req=1 -> mem_en high exactly 16 cycles;
//     then dm_ready=1 and bus_err=1 for one cycle, dm_rdata=0; FSM back in IDLE.
//  5. rst asserted during the 2nd cycle of a delayed I_ACC -> mem_en, state and outputs reach
//     reset values before the next edge; no if_ready pulse.
//     After rst release with if_req still high -> normal fetch.
//  6. With ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, dm_req and if_req held high
//     -> grant sequence D,D,D,D,I,D,...
//     Without the macro -> D forever; if_ready never pulses.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline's IF/MEM ports, the arbiter, and the unified memory.
// The slave modport is the arbiter's view; master is the pipeline+memory side.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  // data port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          bus_err;
  // memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, bus_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, bus_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port memory between the IF (fetch) and
// MEM (load/store) stages. Data port has priority; each access is req/ack sequenced,
// times out after TIMEOUT cycles without mem_ack, and always passes through DONE so a
// still-high request is not re-granted in the cycle it sees ready.
// Optional feature: define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT
// consecutive data grants made while IF was waiting.
module unified_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("unified_mem_arbiter: TIMEOUT must be at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("unified_mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic          if_ready_q;
  logic          dm_ready_q;
  logic          bus_err_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          grant_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starve_hit;

  // IF is forced through once the data port has won STARVE_LIMIT times in a row
  // while IF was waiting; with IF idle the data port still gets the grant.
  assign starve_hit = bus.if_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign grant_d    = bus.dm_req && !starve_hit;

  // Count data grants made over a pending fetch; clear on every fetch grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_d) begin
        if (bus.if_req && (starve_cnt != SW'(STARVE_LIMIT)))
          starve_cnt <= starve_cnt + SW'(1);
      end else if (bus.if_req) begin
        starve_cnt <= '0;
      end
    end
  end
`else
  assign grant_d = bus.dm_req;
`endif

  // Arbitration FSM with registered completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      bus_err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          tmr <= '0;
          if (grant_d)
            state <= D_ACC;
          else if (bus.if_req)
            state <= I_ACC;
        end
        I_ACC: begin
          if (bus.mem_ack) begin
            state      <= DONE;
            if_ready_q <= 1'b1;
            if_rdata_q <= bus.mem_rdata;
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            state      <= DONE;
            if_ready_q <= 1'b1;
            if_rdata_q <= '0;
            bus_err_q  <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        D_ACC: begin
          if (bus.mem_ack) begin
            state      <= DONE;
            dm_ready_q <= 1'b1;
            dm_rdata_q <= bus.dm_we ? '0 : bus.mem_rdata;
          end else if (tmr == TW'(TIMEOUT - 1)) begin
            state      <= DONE;
            dm_ready_q <= 1'b1;
            dm_rdata_q <= '0;
            bus_err_q  <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so reset drops mem_en immediately.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state)
      I_ACC: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
      end
      D_ACC: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = bus.dm_addr;
        bus.mem_wdata = bus.dm_wdata;
      end
      default: ;
    endcase
  end

  assign bus.if_ready = if_ready_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_ready = dm_ready_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.bus_err  = bus_err_q;

endmodule
